load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
- Memory-access stage directly downstream of the 64-bit ALU.
- Takes the ALU result as the effective address and rs2 as store data.
- Issues one aligned 64-bit access on a req/gnt/rvalid data bus.
- Returns sign- or zero-extended load data, or a store acknowledge, to writeback via a single-outstanding valid/ready handshake.

Parameters:
- TIMEOUT_CYCLES, 255: bus cycles allowed from mem_req assertion to mem_rvalid before abort. Used only with LSU_BUS_TIMEOUT_EN.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- req_valid  in  1  core access request.
- req_ready  out  1  LSU can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_funct3  in  3  RISC-V funct3. Loads: 0 LB, 1 LH, 2 LW, 3 LD, 4 LBU, 5 LHU, 6 LWU. Stores: 0 SB, 1 SH, 2 SW, 3 SD.
- req_addr  in  64  effective address (alu_result).
- req_wdata  in  64  store data (rs2), value in the low bits.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  64  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned, illegal funct3, or timeout; valid with rsp_valid.
- mem_req  out  1  bus request, held until mem_gnt.
- mem_gnt  in  1  bus accepts the request this cycle.
- mem_we  out  1  bus write.
- mem_addr  out  64  req_addr with bits [2:0] forced to 0.
- mem_wstrb  out  8  byte-lane enables.
- mem_wdata  out  64  lane-aligned store data.
- mem_rvalid  in  1  read data or write acknowledge.
- mem_rdata  in  64  read doubleword.

Behaviour:
- Reset values: req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_err=0; mem_req=0, mem_we=0, mem_addr=0, mem_wstrb=0, mem_wdata=0; state IDLE.
- States: IDLE, REQ, WAIT, RESP.
- req_ready=1 only in IDLE. A request is accepted when req_valid && req_ready. All request fields are registered on acceptance.
- IDLE, on acceptance:
  - If illegal (funct3=7 on a load, funct3>=4 on a store) or misaligned (H: addr[0]; W: addr[1:0]; D: addr[2:0] nonzero) -> RESP with err=1. No bus activity.
  - Otherwise -> REQ.
- REQ: mem_req=1 with stable mem_addr/mem_we/mem_wstrb/mem_wdata. On mem_gnt -> WAIT, and mem_req drops the next cycle.
- WAIT: on mem_rvalid, capture data -> RESP.
- RESP: rsp_valid=1 for exactly one cycle, then -> IDLE.
- rsp_valid is a pulse; writeback must accept it, there is no backpressure.
- Minimum latency: accept at cycle N, mem_req at N+1, gnt at N+1, rvalid at N+2, rsp_valid at N+3. Error responses arrive at N+1.
- Byte offset o = addr[2:0].
- Store data and strobes:
  - mem_wdata = req_wdata << (8*o).
  - mem_wstrb = size mask (B 0x01, H 0x03, W 0x0F, D 0xFF) << o.
  - For loads, mem_wstrb=0.
- Load data: take x = mem_rdata >> (8*o), then truncate to the access size and sign-extend (LB/LH/LW) or zero-extend (LBU/LHU/LWU). LD passes all 64 bits.
- Bus signal qualification:
  - mem_rvalid is ignored outside WAIT, which covers stale responses after a reset.
  - mem_gnt is ignored outside REQ.
  - The bus never raises rvalid in the same cycle as gnt.
- req_valid in a non-IDLE state is not accepted. The requester holds it until ready.
- Asynchronous reset mid-access: immediately forces IDLE and drops mem_req. No response is issued for the aborted access.

Optional Feature:
- Macro LSU_BUS_TIMEOUT_EN.
- When defined:
  - A counter clears on entry to REQ and increments each cycle in REQ or WAIT.
  - Reaching TIMEOUT_CYCLES goes to RESP with rsp_err=1 and rsp_rdata=0, and drops mem_req.
  - A late mem_rvalid afterwards is ignored.
- When not defined: no counter; REQ/WAIT wait indefinitely.

Test Plan:
- LB at addr 0x1003, mem_rdata=0x0000_0000_80FF_0000 (byte 3 = 0x80) -> rsp_rdata=0xFFFF_FFFF_FFFF_FF80, err=0; LBU same -> 0x80.
- SH at addr 0x2006, wdata=0xABCD, gnt immediate -> mem_addr=0x2000, mem_wstrb=0xC0, mem_wdata=0xABCD_0000_0000_0000; ack -> rsp_valid with rdata=0, err=0.
- LW at addr 0x3002 -> rsp_valid at N+1 with err=1; mem_req never asserted.
- LD at addr 0x4000, gnt held low 5 cycles, then rvalid 2 cycles after gnt with 0x1122334455667788 -> mem_req stable for 6 cycles, rsp_rdata=0x1122334455667788 exactly one cycle.
- Reset asserted in WAIT, rvalid arrives after release -> no rsp_valid, req_ready=1, next LWU at 0x10 with word 0xF000_0000 -> 0x0000_0000_F000_0000.
- With LSU_BUS_TIMEOUT_EN and TIMEOUT_CYCLES=4, no gnt -> rsp_err=1 after 4 cycles of mem_req; without the macro, mem_req stays high.

Source files
------------

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - memory-access stage: one aligned 64-bit bus access per request, extended load data back
// Optional bus timeout enabled by `define LSU_BUS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
module load_store_unit #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        rsp_valid,
  output logic [63:0] rsp_rdata,
  output logic        rsp_err,
  output logic        mem_req,
  input  logic        mem_gnt,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [7:0]  mem_wstrb,
  output logic [63:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [63:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;

  state_t      state_q, state_d;
  logic        we_q, we_d;
  logic [2:0]  funct3_q, funct3_d;
  logic [2:0]  off_q, off_d;
  logic        req_ready_q, req_ready_d;
  logic        rsp_valid_q, rsp_valid_d;
  logic [63:0] rsp_rdata_q, rsp_rdata_d;
  logic        rsp_err_q, rsp_err_d;
  logic        mem_req_q, mem_req_d;
  logic        mem_we_q, mem_we_d;
  logic [63:0] mem_addr_q, mem_addr_d;
  logic [7:0]  mem_wstrb_q, mem_wstrb_d;
  logic [63:0] mem_wdata_q, mem_wdata_d;
`ifdef LSU_BUS_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
`endif

  logic        illegal, misaligned;
  logic [7:0]  size_mask;
  logic [63:0] shifted, load_ext;

  always_comb begin
    illegal = req_we ? req_funct3[2] : (req_funct3 == 3'd7);
    case (req_funct3[1:0])
      2'd0:    begin misaligned = 1'b0;                    size_mask = 8'h01; end
      2'd1:    begin misaligned = req_addr[0];             size_mask = 8'h03; end
      2'd2:    begin misaligned = (req_addr[1:0] != 2'd0); size_mask = 8'h0F; end
      default: begin misaligned = (req_addr[2:0] != 3'd0); size_mask = 8'hFF; end
    endcase
  end

  // Bring the addressed lane down to bit 0, then truncate and extend by access type.
  always_comb begin
    shifted = mem_rdata >> {off_q, 3'b000};
    case (funct3_q)
      3'd0:    load_ext = {{56{shifted[7]}},  shifted[7:0]};
      3'd1:    load_ext = {{48{shifted[15]}}, shifted[15:0]};
      3'd2:    load_ext = {{32{shifted[31]}}, shifted[31:0]};
      3'd4:    load_ext = {56'd0, shifted[7:0]};
      3'd5:    load_ext = {48'd0, shifted[15:0]};
      3'd6:    load_ext = {32'd0, shifted[31:0]};
      default: load_ext = shifted;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    we_d        = we_q;
    funct3_d    = funct3_q;
    off_d       = off_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wstrb_d = mem_wstrb_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LSU_BUS_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      IDLE: if (req_valid && req_ready_q) begin
        we_d     = req_we;
        funct3_d = req_funct3;
        off_d    = req_addr[2:0];
        if (illegal || misaligned) begin
          state_d     = RESP;
          rsp_rdata_d = 64'd0;
          rsp_err_d   = 1'b1;
        end else begin
          state_d     = REQ;
          mem_we_d    = req_we;
          mem_addr_d  = {req_addr[63:3], 3'b000};
          mem_wstrb_d = req_we ? (size_mask << req_addr[2:0]) : 8'h00;
          mem_wdata_d = req_wdata << {req_addr[2:0], 3'b000};
`ifdef LSU_BUS_TIMEOUT_EN
          cnt_d       = 32'd0;
`endif
        end
      end
      REQ:  if (mem_gnt) state_d = WAIT;
      WAIT: if (mem_rvalid) begin
        state_d     = RESP;
        rsp_rdata_d = we_q ? 64'd0 : load_ext;
        rsp_err_d   = 1'b0;
      end
      default: state_d = IDLE;
    endcase
`ifdef LSU_BUS_TIMEOUT_EN
    // A response arriving on the final allowed cycle still wins over the abort.
    if (state_q == REQ || state_q == WAIT) begin
      cnt_d = cnt_q + 32'd1;
      if (state_d != RESP && cnt_q == 32'(TIMEOUT_CYCLES - 1)) begin
        state_d     = RESP;
        rsp_rdata_d = 64'd0;
        rsp_err_d   = 1'b1;
      end
    end
`endif
    req_ready_d = (state_d == IDLE);
    mem_req_d   = (state_d == REQ);
    rsp_valid_d = (state_d == RESP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      funct3_q    <= 3'd0;
      off_q       <= 3'd0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 64'd0;
      rsp_err_q   <= 1'b0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= 64'd0;
      mem_wstrb_q <= 8'd0;
      mem_wdata_q <= 64'd0;
`ifdef LSU_BUS_TIMEOUT_EN
      cnt_q       <= 32'd0;
`endif
    end else begin
      state_q     <= state_d;
      we_q        <= we_d;
      funct3_q    <= funct3_d;
      off_q       <= off_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wstrb_q <= mem_wstrb_d;
      mem_wdata_q <= mem_wdata_d;
`ifdef LSU_BUS_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wstrb = mem_wstrb_q;
  assign mem_wdata = mem_wdata_q;
endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed self-checking bench for load_store_unit
module tb_load_store_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_funct3 = 3'd0;
  logic [63:0] req_addr = 64'd0;
  logic [63:0] req_wdata = 64'd0;
  logic        rsp_valid;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_gnt = 1'b0;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [7:0]  mem_wstrb;
  logic [63:0] mem_wdata;
  logic        mem_rvalid = 1'b0;
  logic [63:0] mem_rdata = 64'd0;

  int total = 0;
  int bad = 0;

  load_store_unit #(.TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Results of the most recent access
  int          rsp_cyc, rsp_cnt, req_cyc, unstable;
  logic [63:0] rd, cap_addr, cap_wdata;
  logic        er, cap_we;
  logic [7:0]  cap_wstrb;

  // Drive one request at a negedge (cycle N) and play the bus for 30 cycles.
  task automatic run_access(input logic we, input logic [2:0] f3, input logic [63:0] addr,
                            input logic [63:0] wdata, input int gnt_wait, input int rv_wait,
                            input logic [63:0] rdata);
    int gnt_seen;
    int since_gnt;
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    rsp_cyc = -1; rsp_cnt = 0; req_cyc = 0; unstable = 0; rd = 64'd0; er = 1'b0;
    gnt_seen = 0; since_gnt = 0;
    for (int c = 1; c <= 30; c++) begin
      @(negedge clk);
      req_valid = 1'b0; mem_gnt = 1'b0; mem_rvalid = 1'b0;
      if (rsp_valid) begin
        rsp_cnt++;
        if (rsp_cyc < 0) rsp_cyc = c;
        rd = rsp_rdata; er = rsp_err;
      end
      if (mem_req) begin
        req_cyc++;
        if (req_cyc == 1) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_we = mem_we; cap_wstrb = mem_wstrb;
        end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                     mem_we !== cap_we || mem_wstrb !== cap_wstrb) begin
          unstable++;
        end
        if (req_cyc > gnt_wait && gnt_seen == 0) begin
          mem_gnt = 1'b1; gnt_seen = 1;
        end
      end else if (gnt_seen != 0) begin
        since_gnt++;
        if (since_gnt == rv_wait) begin
          mem_rvalid = 1'b1; mem_rdata = rdata;
        end
      end
    end
  endtask

  initial begin
    int seen;
    @(negedge clk);
    check("rst_ready", {63'd0, req_ready}, 64'd1);
    check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
    check("rst_mem_req", {63'd0, mem_req}, 64'd0);
    check("rst_mem_addr", mem_addr, 64'd0);
    check("rst_mem_wstrb", {56'd0, mem_wstrb}, 64'd0);
    check("rst_rsp_rdata", rsp_rdata, 64'd0);
    rst = 1'b0;
    @(negedge clk);

    run_access(1'b0, 3'd0, 64'h1003, 64'd0, 0, 1, 64'h0000_0000_80FF_0000);
    check("lb_data", rd, 64'hFFFF_FFFF_FFFF_FF80);
    check("lb_err", {63'd0, er}, 64'd0);
    check("lb_latency", 64'(rsp_cyc), 64'd3);
    check("lb_pulses", 64'(rsp_cnt), 64'd1);
    check("lb_addr", cap_addr, 64'h1000);
    check("lb_wstrb", {56'd0, cap_wstrb}, 64'd0);

    run_access(1'b0, 3'd4, 64'h1003, 64'd0, 0, 1, 64'h0000_0000_80FF_0000);
    check("lbu_data", rd, 64'h80);

    run_access(1'b1, 3'd1, 64'h2006, 64'hABCD, 0, 1, 64'd0);
    check("sh_addr", cap_addr, 64'h2000);
    check("sh_wstrb", {56'd0, cap_wstrb}, 64'hC0);
    check("sh_wdata", cap_wdata, 64'hABCD_0000_0000_0000);
    check("sh_we", {63'd0, cap_we}, 64'd1);
    check("sh_rdata", rd, 64'd0);
    check("sh_err", {63'd0, er}, 64'd0);
    check("sh_pulses", 64'(rsp_cnt), 64'd1);

    run_access(1'b0, 3'd2, 64'h3002, 64'd0, 0, 1, 64'd0);
    check("lw_mis_latency", 64'(rsp_cyc), 64'd1);
    check("lw_mis_err", {63'd0, er}, 64'd1);
    check("lw_mis_noreq", 64'(req_cyc), 64'd0);
    check("lw_mis_rdata", rd, 64'd0);

    run_access(1'b1, 3'd4, 64'h3000, 64'h55, 0, 1, 64'd0);
    check("st_ill_err", {63'd0, er}, 64'd1);
    check("st_ill_noreq", 64'(req_cyc), 64'd0);
    run_access(1'b0, 3'd7, 64'h3000, 64'd0, 0, 1, 64'd0);
    check("ld_ill_err", {63'd0, er}, 64'd1);

    run_access(1'b0, 3'd3, 64'h4000, 64'd0, 5, 2, 64'h1122_3344_5566_7788);
    check("ld_req_cycles", 64'(req_cyc), 64'd6);
    check("ld_stable", 64'(unstable), 64'd0);
    check("ld_data", rd, 64'h1122_3344_5566_7788);
    check("ld_pulses", 64'(rsp_cnt), 64'd1);
    check("ld_latency", 64'(rsp_cyc), 64'd9);

    run_access(1'b0, 3'd2, 64'h5004, 64'd0, 0, 1, 64'h89AB_CDEF_0000_0000);
    check("lw_sign", rd, 64'hFFFF_FFFF_89AB_CDEF);

    // Reset while waiting for read data; the stale rvalid must be ignored.
    req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd3; req_addr = 64'h6000;
    @(negedge clk);
    req_valid = 1'b0; mem_gnt = 1'b1;
    @(negedge clk);
    mem_gnt = 1'b0;
    rst = 1'b1;
    #1;
    check("arst_mem_req", {63'd0, mem_req}, 64'd0);
    check("arst_ready", {63'd0, req_ready}, 64'd1);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    mem_rvalid = 1'b1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
    seen = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      mem_rvalid = 1'b0;
      if (rsp_valid) seen++;
    end
    check("arst_no_rsp", 64'(seen), 64'd0);
    check("arst_ready_after", {63'd0, req_ready}, 64'd1);
    run_access(1'b0, 3'd6, 64'h10, 64'd0, 0, 1, 64'h0000_0000_F000_0000);
    check("lwu_data", rd, 64'h0000_0000_F000_0000);
    check("lwu_err", {63'd0, er}, 64'd0);

    run_access(1'b0, 3'd3, 64'h7000, 64'd0, 1000, 1, 64'd0);
`ifdef LSU_BUS_TIMEOUT_EN
    check("to_req_cycles", 64'(req_cyc), 64'd4);
    check("to_latency", 64'(rsp_cyc), 64'd5);
    check("to_err", {63'd0, er}, 64'd1);
    check("to_rdata", rd, 64'd0);
`else
    check("noto_req_held", 64'(req_cyc), 64'd30);
    check("noto_no_rsp", 64'(rsp_cnt), 64'd0);
`endif
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
